// File: rtl/regfile_mp.sv
// regfile_mp: parametrised two-write, multi-read register file with optional bypass and registered read
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS = 1'b1,
  parameter bit READ_REG = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           RegWrite0,
  input  logic [ADDR_WIDTH-1:0]          WriteRegister0,
  input  logic [DATA_WIDTH-1:0]          WriteData0,
  input  logic                           RegWrite1,
  input  logic [ADDR_WIDTH-1:0]          WriteRegister1,
  input  logic [DATA_WIDTH-1:0]          WriteData1,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] ReadRegister,
  output logic [NUM_READ*DATA_WIDTH-1:0] ReadData
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [NUM_READ*DATA_WIDTH-1:0] effData;
  // Port 1 is checked first so it wins a same-index conflict.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst || (ZERO_REG && i == 0)) mem[i] <= '0;
      else if (RegWrite1 && WriteRegister1 == ADDR_WIDTH'(i)) mem[i] <= WriteData1;
      else if (RegWrite0 && WriteRegister0 == ADDR_WIDTH'(i)) mem[i] <= WriteData0;
    end
  end
  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] readIdx;
    assign readIdx = ReadRegister[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign effData[k*DATA_WIDTH +: DATA_WIDTH] =
      (ZERO_REG && readIdx == '0) ? '0 :
      (BYPASS && RegWrite1 && WriteRegister1 == readIdx) ? WriteData1 :
      (BYPASS && RegWrite0 && WriteRegister0 == readIdx) ? WriteData0 :
      mem[readIdx];
  end
  if (READ_REG) begin : g_reg
    logic [NUM_READ*DATA_WIDTH-1:0] readQ;
    always_ff @(posedge clk) readQ <= rst ? '0 : effData;
    assign ReadData = readQ;
  end else begin : g_comb
    assign ReadData = rst ? '0 : effData;
  end
endmodule
